// File: rtl/vote_capture_ctrl.sv
// Single-voter session sequencer for a 16-candidate ballot unit: arms on issue,
// debounces a one-hot button code, commits one vote into saturating tallies.
module vote_capture_ctrl #(
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int COUNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ballot_issue,
  input  logic [15:0]        button,
  input  logic               clear_tally,
  input  logic [3:0]         rd_idx,
  output logic               armed,
  output logic               vote_valid,
  output logic [3:0]         vote_idx,
  output logic               multi_err,
  output logic               timeout,
  output logic [COUNT_W-1:0] rd_count,
  output logic [COUNT_W-1:0] total_votes
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int TOUT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_SCAN, S_COMMIT, S_RELEASE
  } state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TOUT_W-1:0]   tout_q, tout_d;
  logic [3:0]          cap_q, cap_d;
  logic [3:0]          vote_idx_d;
  logic                multi_d, tout_pulse_d, commit, tout_hit;
  logic [COUNT_W-1:0]  tally_q [16];
  logic [COUNT_W-1:0]  total_q;

  // Button decode: OR of set-bit indices is exact for a one-hot code and is
  // never used otherwise, so a multi-press cannot be priority-resolved.
  logic        btn_none, btn_one, btn_multi;
  logic [3:0]  btn_idx;

  always_comb begin
    btn_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (button[i]) btn_idx = btn_idx | 4'(i);
    end
  end

  assign btn_none  = (button == 16'd0);
  assign btn_one   = !btn_none && ((button & (button - 16'd1)) == 16'd0);
  assign btn_multi = !btn_none && !btn_one;
  assign tout_hit  = (tout_q == TOUT_W'(TIMEOUT_CYCLES - 1));

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d      = state_q;
    hold_d       = '0;
    tout_d       = tout_q;
    cap_d        = cap_q;
    multi_d      = 1'b0;
    tout_pulse_d = 1'b0;
    commit       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ballot_issue) begin
          state_d = S_ARMED;
          tout_d  = '0;
        end
      end
      S_ARMED: begin
        tout_d = tout_q + 1'b1;
        if (tout_hit) begin
          state_d      = S_IDLE;
          tout_pulse_d = 1'b1;
        end else if (btn_none) begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        tout_d = tout_q + 1'b1;
        if (btn_none) begin
          hold_d = '0;
        end else if (btn_multi) begin
          hold_d = '0;
        end else if (btn_idx != cap_q || hold_q == '0) begin
          cap_d  = btn_idx;
          hold_d = HOLD_W'(1);
        end else begin
          hold_d = hold_q + 1'b1;
          commit = (hold_q == HOLD_W'(HOLD_CYCLES - 1));
        end
        // A commit on the timeout edge takes precedence over abandoning.
        if (commit) begin
          state_d = S_COMMIT;
        end else if (tout_hit) begin
          state_d      = S_IDLE;
          tout_pulse_d = 1'b1;
        end
        multi_d = btn_multi && (state_d == S_SCAN);
      end
      S_COMMIT:  state_d = S_RELEASE;
      S_RELEASE: if (btn_none) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign vote_idx_d = commit ? btn_idx : vote_idx;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      tout_q     <= '0;
      cap_q      <= '0;
      armed      <= 1'b0;
      vote_valid <= 1'b0;
      vote_idx   <= '0;
      multi_err  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      tout_q     <= tout_d;
      cap_q      <= cap_d;
      armed      <= (state_d == S_ARMED) || (state_d == S_SCAN);
      vote_valid <= (state_d == S_COMMIT);
      vote_idx   <= vote_idx_d;
      multi_err  <= multi_d;
      timeout    <= tout_pulse_d;
    end
  end

  // NOTE: the tally array must read zero straight out of reset, so it is built
  // from resettable flops rather than a RAM macro that cannot be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) tally_q[i] <= '0;
      total_q <= '0;
    end else if (state_q == S_COMMIT) begin
      if (tally_q[cap_q] != {COUNT_W{1'b1}}) tally_q[cap_q] <= tally_q[cap_q] + 1'b1;
      if (total_q != {COUNT_W{1'b1}}) total_q <= total_q + 1'b1;
    end else if (state_q == S_IDLE && clear_tally) begin
      for (int i = 0; i < 16; i++) tally_q[i] <= '0;
      total_q <= '0;
    end
  end

  assign rd_count    = tally_q[rd_idx];
  assign total_votes = total_q;

endmodule

// File: tb/tb_vote_capture_ctrl.sv
// Scoreboard bench for vote_capture_ctrl: expected vote indices are queued as
// committing presses are driven and popped when vote_valid is seen.
module tb_vote_capture_ctrl;

  localparam int HOLD    = 4;
  localparam int TOUT    = 20;
  localparam int CW      = 2;

  logic          clk;
  logic          rst_n;
  logic          ballot_issue;
  logic [15:0]   button;
  logic          clear_tally;
  logic [3:0]    rd_idx;
  logic          armed, vote_valid, multi_err, timeout;
  logic [3:0]    vote_idx;
  logic [CW-1:0] rd_count, total_votes;

  int n_cmp = 0;
  int n_err = 0;
  int tout_cnt = 0;
  int sb[$];

  vote_capture_ctrl #(
    .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TOUT), .COUNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ballot_issue(ballot_issue), .button(button),
    .clear_tally(clear_tally), .rd_idx(rd_idx), .armed(armed),
    .vote_valid(vote_valid), .vote_idx(vote_idx), .multi_err(multi_err),
    .timeout(timeout), .rd_count(rd_count), .total_votes(total_votes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor on the falling edge: every vote pulse must match the queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (vote_valid) begin
        if (sb.size() == 0) check("vote_unexpected", vote_valid, 1'b0);
        else check("vote_idx", vote_idx, sb.pop_front());
      end
      if (timeout) tout_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue();
    ballot_issue = 1'b1;
    step();
    ballot_issue = 1'b0;
  endtask

  task automatic do_clear();
    clear_tally = 1'b1;
    step();
    clear_tally = 1'b0;
  endtask

  task automatic rd_check(input string tag, input int idx, input int exp);
    rd_idx = 4'(idx);
    #1;
    check(tag, rd_count, exp);
  endtask

  task automatic do_vote(input int k, input int hold);
    issue();
    check("armed_on", armed, 1'b1);
    step();
    sb.push_back(k);
    button = '0;
    button[k] = 1'b1;
    repeat (hold) step();
    button = '0;
    repeat (3) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int t0;
    rst_n = 1'b0; ballot_issue = 1'b0; button = '0; clear_tally = 1'b0; rd_idx = '0;
    repeat (3) step();
    check("rst_armed", armed, 0);
    check("rst_vote_valid", vote_valid, 0);
    check("rst_vote_idx", vote_idx, 0);
    check("rst_multi_err", multi_err, 0);
    check("rst_timeout", timeout, 0);
    check("rst_total", total_votes, 0);
    rd_check("rst_tally0", 0, 0);
    rst_n = 1'b1;
    step();

    // Normal vote, button held beyond the debounce window.
    do_vote(5, 6);
    check("t1_armed_off", armed, 0);
    rd_check("t1_tally5", 5, 1);
    check("t1_total", total_votes, 1);

    // Multi-press is flagged and never resolved to a single candidate.
    do_clear();
    check("clr_total", total_votes, 0);
    rd_check("clr_tally5", 5, 0);
    issue();
    step();
    button = 16'h0044;
    step();
    check("multi_set", multi_err, 1);
    repeat (4) step();
    check("multi_hold", multi_err, 1);
    sb.push_back(6);
    button = 16'h0040;
    step();
    check("multi_clr", multi_err, 0);
    repeat (3) step();
    button = '0;
    repeat (3) step();
    rd_check("multi_tally6", 6, 1);
    check("multi_total", total_votes, 1);

    // Button held across issue must be released and re-pressed.
    do_clear();
    button = 16'h8000;
    issue();
    repeat (3) step();
    check("preheld_armed", armed, 1);
    button = '0;
    step();
    sb.push_back(15);
    button = 16'h8000;
    repeat (4) step();
    button = '0;
    repeat (3) step();
    // Bouncing between two candidates never accumulates a full hold.
    issue();
    step();
    for (int r = 0; r < 2; r++) begin
      button = 16'h0002; repeat (2) step();
      button = 16'h0001; repeat (2) step();
    end
    sb.push_back(1);
    button = 16'h0002;
    repeat (4) step();
    button = '0;
    repeat (3) step();
    rd_check("bounce_tally15", 15, 1);
    rd_check("bounce_tally1", 1, 1);
    rd_check("bounce_tally0", 0, 0);
    check("bounce_total", total_votes, 2);

    // Abandoned session after TOUT cycles in ARMED+SCAN.
    do_clear();
    issue();
    n = 0;
    do begin
      step();
      n++;
    end while (!timeout && n < 40);
    check("tout_latency", n, TOUT);
    check("tout_armed_off", armed, 0);
    step();
    check("tout_one_cycle", timeout, 0);
    check("tout_total", total_votes, 0);
    do_vote(9, 4);
    rd_check("tout_retry_tally9", 9, 1);
    // Commit landing on the timeout edge wins over the abandon.
    t0 = tout_cnt;
    issue();
    repeat (16) step();
    sb.push_back(12);
    button = 16'h1000;
    repeat (4) step();
    button = '0;
    repeat (3) step();
    check("tout_vs_commit", tout_cnt - t0, 0);
    check("tout_vs_commit_total", total_votes, 2);

    // Lockout: re-press in RELEASE, press in IDLE and issue in SCAN all ignored.
    do_clear();
    issue();
    step();
    sb.push_back(3);
    button = 16'h0008;
    step();
    ballot_issue = 1'b1;
    step();
    ballot_issue = 1'b0;
    repeat (4) step();
    button = 16'h0001;
    repeat (2) step();
    button = '0;
    repeat (2) step();
    check("lock_no_requeue", armed, 0);
    button = 16'h0004;
    repeat (6) step();
    button = '0;
    step();
    rd_check("lock_tally3", 3, 1);
    rd_check("lock_tally0", 0, 0);
    rd_check("lock_tally2", 2, 0);
    check("lock_total", total_votes, 1);
    // Saturation of tally and total, each independently.
    for (int s = 0; s < 3; s++) do_vote(3, 4);
    rd_check("sat_tally3", 3, 3);
    check("sat_total", total_votes, 3);
    do_vote(1, 4);
    rd_check("sat_tally1", 1, 1);
    check("sat_total_hold", total_votes, 3);

    // Clear is ignored outside IDLE.
    issue();
    step();
    clear_tally = 1'b1;
    step();
    clear_tally = 1'b0;
    sb.push_back(1);
    button = 16'h0002;
    repeat (4) step();
    button = '0;
    repeat (3) step();
    rd_check("scan_clr_tally3", 3, 3);
    rd_check("scan_clr_tally1", 1, 2);
    // Clear and issue together: counters zeroed and the session still starts.
    clear_tally = 1'b1;
    ballot_issue = 1'b1;
    step();
    clear_tally = 1'b0;
    ballot_issue = 1'b0;
    check("clr_issue_armed", armed, 1);
    check("clr_issue_total", total_votes, 0);
    rd_check("clr_issue_tally3", 3, 0);
    step();
    sb.push_back(2);
    button = 16'h0004;
    repeat (4) step();
    button = '0;
    repeat (3) step();
    check("clr_issue_vote_total", total_votes, 1);

    // Reset in the middle of a partial debounce.
    issue();
    step();
    button = 16'h0010;
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    check("midrst_armed", armed, 0);
    check("midrst_total", total_votes, 0);
    check("midrst_vote_idx", vote_idx, 0);
    rd_check("midrst_tally2", 2, 0);
    button = '0;
    step();
    rst_n = 1'b1;
    step();
    do_vote(7, 4);
    rd_check("post_rst_tally7", 7, 1);
    check("post_rst_total", total_votes, 1);

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
